pattern_serializer: RTL and testbench
=====================================

# pattern_serializer

Loads an 8-bit switch word and transmits it serially, LSB first (bit 0 = switch 1), one bit per programmable bit period. It is the transmit end of the switch-pattern path: it produces the bit stream that the pattern-detect logic consumes. While transmitting, it also flags the same two patterns on the transmitted stream, so the receive side can be cross-checked:
- a run of three consecutive 1s;
- a run of two consecutive 0s.

## Interface
Parameters:
- BIT_TICKS, 4 — clock cycles per transmitted bit; legal range 1..255.

Ports:
- clk  in  1  — system clock; all state changes on its rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- start  in  1  — load request; sampled only in IDLE.
- data_in  in  8  — word to send; bit 0 = switch 1 (LSB), bit 7 = switch 8 (MSB).
- ser_out  out  1  — serial data; 0 when not transmitting.
- ser_valid  out  1  — high while ser_out carries a frame bit.
- busy  out  1  — high from the cycle after start acceptance through the final bit period.
- done  out  1  — one-cycle pulse after the last bit period ends.
- ones3  out  1  — sticky per frame: three consecutive 1s have been transmitted.
- zeros2  out  1  — sticky per frame: two consecutive 0s have been transmitted.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: capture data_in into shift_reg, clear bit_cnt (3 bits), tick_cnt, ones3, zeros2, and run history. Go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - ser_out = shift_reg[0]; ser_valid=1; busy=1.
  - tick_cnt counts 0..BIT_TICKS-1.
  - At tick_cnt = BIT_TICKS-1, the bit is committed:
    - Update run counters from shift_reg[0].
    - Shift shift_reg right by one (zero-filled).
    - Reset tick_cnt.
    - If bit_cnt = 7, go to DONE; else increment bit_cnt.
- DONE:
  - done=1 for exactly one cycle; ser_valid=0; busy=0; ser_out=0.
  - Next state IDLE unconditionally.
- Pattern tracking:
  - ones_run is a 2-bit saturating counter of consecutive committed 1s. A committed 0 clears it.
  - ones3 sets when a committed 1 occurs with ones_run already = 2.
  - zeros2 sets when a committed 0 follows a committed 0 in the same frame.
  - Runs do not span frames.
  - ones3 and zeros2 hold their values through DONE and IDLE until the next start is accepted.
- start is ignored in SHIFT and DONE; there is no queuing.
- data_in is sampled only on the acceptance cycle. Later changes do not affect the frame in flight.

## Timing
- Reset (async assert, sync-to-clk release) forces:
  - state=IDLE; ser_out=0; ser_valid=0; busy=0; done=0; ones3=0; zeros2=0;
  - shift_reg, bit_cnt, tick_cnt and run history all 0.
- Start accepted at edge E0. The first bit appears on ser_out in the cycle after E0, with busy=ser_valid=1.
- Each bit is held for exactly BIT_TICKS cycles. The frame occupies 8×BIT_TICKS cycles.
- done is high in cycle 8×BIT_TICKS+1 after E0.
- The earliest next start is accepted in the cycle after done (IDLE). Back-to-back frame spacing is 8×BIT_TICKS+2 cycles.
- BIT_TICKS=1: ser_out changes every cycle. Flag updates still occur at each commit.
- ones3 and zeros2 update at the commit edge of the qualifying bit. They become visible in the first cycle of the following bit, or in DONE for bit 7.
- Reset asserted mid-frame: all outputs drop immediately, with no done pulse. After release the block is in IDLE and waits for a fresh start.
- start held high continuously: a new frame is accepted each time the FSM is in IDLE.

## Test plan
- Reset mid-frame:
  - Stimulus: BIT_TICKS=4, data_in=8'hA5; start a frame, then assert rst_n=0 during bit 3.
  - Required: every output is 0 within the same cycle (asynchronous); done never pulses.
  - After release, start with 8'h0F → ser_out = 1,1,1,1,0,0,0,0.
- Basic frame:
  - Stimulus: BIT_TICKS=4, data_in=8'b1110_0101, one-cycle start.
  - Required: ser_out sequence 1,0,1,0,0,1,1,1, each bit held 4 cycles.
  - done pulses at cycle 33 after acceptance.
  - ones3=1 (set at the commit of bit 7); zeros2=1 (set at the commit of bit 4).
- No-pattern word:
  - Stimulus: data_in=8'b0110_1101.
  - Required: ones3=0 and zeros2=0 at done.
- Flags clear between frames:
  - Stimulus: send 8'hFF, then 8'h55 (all BIT_TICKS=1).
  - Required: after frame 1, ones3=1 and zeros2=0.
  - After acceptance of frame 2, ones3 returns to 0; after frame 2, ones3=0 and zeros2=0.
- start held high:
  - Stimulus: start=1 for 40 cycles with BIT_TICKS=1; data_in changes mid-frame.
  - Required: the in-flight frame is unaffected by the data_in change.
  - Frames are accepted at 10-cycle spacing, with exactly one done pulse per frame.

Source files
------------

// File: rtl/pattern_serializer.sv
// pattern_serializer: loads an 8-bit switch word and shifts it out LSB first,
// one bit per BIT_TICKS clocks, while flagging runs of three 1s and two 0s
// on the transmitted stream.
module pattern_serializer #(
    parameter int unsigned BIT_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       busy,
    output logic       done,
    output logic       ones3,
    output logic       zeros2
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned TICK_W = 8;
    localparam int unsigned RUN_W  = 2;

    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(BIT_TICKS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [RUN_W-1:0]  RUN_TWO   = RUN_W'(2);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   shift_reg_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [TICK_W-1:0]   tick_cnt_q;
    logic [RUN_W-1:0]    ones_run_q;
    logic                zero_prev_q;
    logic                ser_out_q;
    logic                ser_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                ones3_q;
    logic                zeros2_q;

    // Frame FSM: load, timed shift with per-commit run tracking, one-cycle done.
    // ser_out is preloaded with the next bit so it is registered yet aligned
    // with the bit period it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            ones_run_q  <= '0;
            zero_prev_q <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ones3_q     <= 1'b0;
            zeros2_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shift_reg_q <= data_in;
                        bit_cnt_q   <= '0;
                        tick_cnt_q  <= '0;
                        ones_run_q  <= '0;
                        zero_prev_q <= 1'b0;
                        ones3_q     <= 1'b0;
                        zeros2_q    <= 1'b0;
                        ser_out_q   <= data_in[0];
                        ser_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_q  <= '0;
                        shift_reg_q <= {1'b0, shift_reg_q[DATA_W-1:1]};
                        // Run history is updated from the bit being committed.
                        if (shift_reg_q[0]) begin
                            if (ones_run_q == RUN_TWO) begin
                                ones3_q <= 1'b1;
                            end
                            if (ones_run_q != RUN_MAX) begin
                                ones_run_q <= ones_run_q + RUN_W'(1);
                            end
                            zero_prev_q <= 1'b0;
                        end else begin
                            if (zero_prev_q) begin
                                zeros2_q <= 1'b1;
                            end
                            zero_prev_q <= 1'b1;
                            ones_run_q  <= '0;
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            ser_out_q   <= 1'b0;
                            ser_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            ser_out_q <= shift_reg_q[1];
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ones3     = ones3_q;
    assign zeros2    = zeros2_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: two instances (BIT_TICKS=4 and 1) checked
// cycle by cycle against a frame-level reference model.
module tb_pattern_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sel;          // 0: BIT_TICKS=4 instance, 1: BIT_TICKS=1 instance
    logic [7:0] data_in;

    logic so4, sv4, b4, d4, o4, z4;
    logic so1, sv1, b1, d1, o1, z1;
    logic start4, start1;
    logic [3:0] obs_out;
    logic [1:0] obs_flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign start4    = start & ~sel;
    assign start1    = start & sel;
    assign obs_out   = sel ? {so1, sv1, b1, d1} : {so4, sv4, b4, d4};
    assign obs_flags = sel ? {o1, z1} : {o4, z4};

    pattern_serializer #(.BIT_TICKS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .data_in(data_in),
        .ser_out(so4), .ser_valid(sv4), .busy(b4), .done(d4),
        .ones3(o4), .zeros2(z4)
    );

    pattern_serializer #(.BIT_TICKS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data_in),
        .ser_out(so1), .ser_valid(sv1), .busy(b1), .done(d1),
        .ones3(o1), .zeros2(z1)
    );

    // Expected {ser_out, ser_valid, busy, done} in cycle c after acceptance.
    function automatic logic [3:0] exp_out(input logic [7:0] w, input int bt, input int c);
        if (c >= 1 && c <= 8 * bt) return {w[(c - 1) / bt], 3'b110};
        if (c == 8 * bt + 1) return 4'b0001;
        return 4'b0000;
    endfunction

    // Expected {ones3, zeros2} in cycle c: a pattern completed by bit j is
    // visible from the first cycle after that bit's period ends.
    function automatic logic [1:0] exp_flags(input logic [7:0] w, input int bt, input int c);
        logic o3 = 1'b0;
        logic z2 = 1'b0;
        for (int j = 1; j < 8; j++) begin
            if ((j + 1) * bt + 1 <= c) begin
                if (!w[j] && !w[j - 1]) z2 = 1'b1;
                if (j >= 2) begin
                    if (w[j] && w[j - 1] && w[j - 2]) o3 = 1'b1;
                end
            end
        end
        return {o3, z2};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one frame from an IDLE cycle and check every cycle through the
    // following IDLE cycle; data_in is scrambled after acceptance.
    task automatic run_frame(input logic [7:0] w, input logic use1, input string tag);
        int bt;
        bt      = use1 ? 1 : 4;
        sel     = use1;
        start   = 1'b1;
        data_in = w;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8 * bt + 2; c++) begin
            chk({tag, "_out"}, 8'(obs_out), 8'(exp_out(w, bt, c)));
            chk({tag, "_flags"}, 8'(obs_flags), 8'(exp_flags(w, bt, c)));
            data_in = 8'($urandom);
            if (c < 8 * bt + 2) step();
        end
    endtask

    initial begin
        logic [7:0] hist [0:40];
        logic [7:0] w;
        int         done_cnt;
        int         k;
        int         o;

        rst_n   = 1'b0;
        start   = 1'b0;
        sel     = 1'b0;
        data_in = 8'h00;
        #2;
        chk("reset_out4", 8'(obs_out), 8'h00);
        chk("reset_flags4", 8'(obs_flags), 8'h00);
        sel = 1'b1;
        #1;
        chk("reset_out1", 8'(obs_out), 8'h00);
        chk("reset_flags1", 8'(obs_flags), 8'h00);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Directed frames
        run_frame(8'hE5, 1'b0, "basic");
        run_frame(8'h6D, 1'b0, "nopat");
        run_frame(8'hFF, 1'b1, "ff_bt1");
        run_frame(8'h55, 1'b1, "55_bt1");

        // Random words on both instances, back to back
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom);
            run_frame(w, 1'b0, "rand4");
        end
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            run_frame(w, 1'b1, "rand1");
        end

        // Reset asserted during bit 3 of an A5 frame
        sel     = 1'b0;
        start   = 1'b1;
        data_in = 8'hA5;
        step();
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            chk("prerst_out", 8'(obs_out), 8'(exp_out(8'hA5, 4, c)));
            if (c < 14) step();
        end
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", 8'(obs_out), 8'h00);
        chk("rst_async_flags", 8'(obs_flags), 8'h00);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_hold_out", 8'(obs_out), 8'h00);
        end
        rst_n = 1'b1;
        step();
        chk("rst_release_out", 8'(obs_out), 8'h00);
        chk("rst_release_flags", 8'(obs_flags), 8'h00);
        run_frame(8'h0F, 1'b0, "after_rst");

        // start held high for 40 cycles with data_in changing every cycle
        sel      = 1'b1;
        done_cnt = 0;
        hist[0]  = 8'($urandom);
        data_in  = hist[0];
        start    = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            k = (c - 1) / 10;
            o = (c - 1) % 10 + 1;
            chk("held_out", 8'(obs_out), 8'(exp_out(hist[10 * k], 1, o)));
            chk("held_flags", 8'(obs_flags), 8'(exp_flags(hist[10 * k], 1, o)));
            if (obs_out[0]) done_cnt++;
            if (c < 40) begin
                hist[c] = 8'($urandom);
                data_in = hist[c];
            end else begin
                start = 1'b0;
            end
        end
        chk("held_done_cnt", 8'(done_cnt), 8'd4);
        step();
        chk("held_idle_out", 8'(obs_out), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
